// File: rtl/warp_rf_if.sv
// Bus bundle for warp_register_file: block init control, masked warp write
// port, dual-source warp read port and status flags.
interface warp_rf_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WARPS  = 4,
  parameter int WARP_SIZE  = 8,
  parameter int NUM_REGS   = 16
);
  localparam int WARP_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int REG_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int LANES_W = WARP_SIZE * DATA_WIDTH;

  logic                  init_start;
  logic [DATA_WIDTH-1:0] block_idx;
  logic [DATA_WIDTH-1:0] block_dim;
  logic                  ready;
  logic                  wr_en;
  logic [WARP_W-1:0]     wr_warp;
  logic [REG_W-1:0]      wr_addr;
  logic [WARP_SIZE-1:0]  wr_mask;
  logic [LANES_W-1:0]    wr_data;
  logic                  wr_err;
  logic                  rd_en;
  logic [WARP_W-1:0]     rd_warp;
  logic [REG_W-1:0]      rs1_addr;
  logic [REG_W-1:0]      rs2_addr;
  logic [LANES_W-1:0]    rs1_data;
  logic [LANES_W-1:0]    rs2_data;
  logic                  rd_valid;

  modport master (
    output init_start, block_idx, block_dim,
    output wr_en, wr_warp, wr_addr, wr_mask, wr_data,
    output rd_en, rd_warp, rs1_addr, rs2_addr,
    input  ready, wr_err, rs1_data, rs2_data, rd_valid
  );

  modport slave (
    input  init_start, block_idx, block_dim,
    input  wr_en, wr_warp, wr_addr, wr_mask, wr_data,
    input  rd_en, rd_warp, rs1_addr, rs2_addr,
    output ready, wr_err, rs1_data, rs2_data, rd_valid
  );
endinterface

// File: rtl/warp_register_file.sv
// Per-thread register file for a block of warps. The top three registers of
// every thread are read-only specials (thread id, block index, block dim)
// loaded by an INIT sweep that visits one warp per cycle and also clears the
// general registers. Reads are registered with write-first bypass.
module warp_register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WARPS  = 4,
  parameter int WARP_SIZE  = 8,
  parameter int NUM_REGS   = 16
) (
  input logic      clk,
  input logic      reset,
  warp_rf_if.slave bus
);
  localparam int WARP_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int REG_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NUM_THREADS   = NUM_WARPS * WARP_SIZE;
  localparam int THREAD_W      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int LANES_W       = WARP_SIZE * DATA_WIDTH;
  localparam int FIRST_SPECIAL = NUM_REGS - 3;
  localparam logic [WARP_W-1:0] LAST_WARP    = WARP_W'(NUM_WARPS - 1);
  localparam logic [REG_W-1:0]  SPECIAL_BASE = REG_W'(FIRST_SPECIAL);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t                state_r;
  logic [WARP_W-1:0]     sweep_warp_r;
  logic                  latch_pending_r;   // first INIT cycle: sample block values
  logic [DATA_WIDTH-1:0] block_idx_r;
  logic [DATA_WIDTH-1:0] block_dim_r;
  logic [DATA_WIDTH-1:0] mem_r [NUM_THREADS][NUM_REGS];
  logic [LANES_W-1:0]    rs1_data_r;
  logic [LANES_W-1:0]    rs2_data_r;
  logic                  rd_valid_r;
  logic                  wr_err_r;

  logic                  ready_s;
  logic                  wr_ok_s;
  logic                  sweep_s;
  logic [DATA_WIDTH-1:0] sweep_idx_s;
  logic [DATA_WIDTH-1:0] sweep_dim_s;
  logic [LANES_W-1:0]    rs1_next_s;
  logic [LANES_W-1:0]    rs2_next_s;

  function automatic logic [THREAD_W-1:0] thread_of(input int warp, input int lane);
    return THREAD_W'(warp * WARP_SIZE + lane);
  endfunction

  // Decode this cycle's actions; the sweep uses live block inputs on its first cycle
  always_comb begin
    ready_s = (state_r == ST_READY);
    wr_ok_s = ready_s && bus.wr_en && (bus.wr_addr < SPECIAL_BASE);
    sweep_s = (state_r == ST_INIT) && !bus.init_start;
    if (latch_pending_r) begin
      sweep_idx_s = bus.block_idx;
      sweep_dim_s = bus.block_dim;
    end else begin
      sweep_idx_s = block_idx_r;
      sweep_dim_s = block_dim_r;
    end
  end

  // INIT/READY sequencing, sweep counter and block value latching
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= ST_INIT;
      sweep_warp_r    <= '0;
      latch_pending_r <= 1'b1;
      block_idx_r     <= '0;
      block_dim_r     <= '0;
    end else begin
      case (state_r)
        ST_READY: begin
          if (bus.init_start) begin
            state_r         <= ST_INIT;
            sweep_warp_r    <= '0;
            latch_pending_r <= 1'b1;
          end
        end
        ST_INIT: begin
          if (bus.init_start) begin
            sweep_warp_r    <= '0;
            latch_pending_r <= 1'b1;
          end else begin
            latch_pending_r <= 1'b0;
            if (latch_pending_r) begin
              block_idx_r <= bus.block_idx;
              block_dim_r <= bus.block_dim;
            end
            if (sweep_warp_r == LAST_WARP) begin
              state_r      <= ST_READY;
              sweep_warp_r <= '0;
            end else begin
              sweep_warp_r <= sweep_warp_r + 1'b1;
            end
          end
        end
        default: begin
          state_r         <= ST_INIT;
          sweep_warp_r    <= '0;
          latch_pending_r <= 1'b1;
        end
      endcase
    end
  end

  // Register storage: sweep rewrites one warp per INIT cycle, masked lane writes in READY
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          mem_r[THREAD_W'(t)][REG_W'(r)] <= '0;
        end
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int l = 0; l < WARP_SIZE; l++) begin
          for (int r = 0; r < NUM_REGS; r++) begin
            if (sweep_s && (w == int'(sweep_warp_r))) begin
              if (r == FIRST_SPECIAL) begin
                mem_r[thread_of(w, l)][REG_W'(r)] <= DATA_WIDTH'(w * WARP_SIZE + l);
              end else if (r == FIRST_SPECIAL + 1) begin
                mem_r[thread_of(w, l)][REG_W'(r)] <= sweep_idx_s;
              end else if (r == FIRST_SPECIAL + 2) begin
                mem_r[thread_of(w, l)][REG_W'(r)] <= sweep_dim_s;
              end else begin
                mem_r[thread_of(w, l)][REG_W'(r)] <= '0;
              end
            end else if (wr_ok_s && (w == int'(bus.wr_warp)) && (r == int'(bus.wr_addr))
                         && bus.wr_mask[l]) begin
              mem_r[thread_of(w, l)][REG_W'(r)] <= bus.wr_data[l*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
    end
  end

  // Read data for both ports with write-first bypass on masked lanes
  always_comb begin
    rs1_next_s = '0;
    rs2_next_s = '0;
    for (int l = 0; l < WARP_SIZE; l++) begin
      if (wr_ok_s && (bus.wr_warp == bus.rd_warp) && (bus.wr_addr == bus.rs1_addr)
          && bus.wr_mask[l]) begin
        rs1_next_s[l*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data[l*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        rs1_next_s[l*DATA_WIDTH +: DATA_WIDTH] = mem_r[thread_of(int'(bus.rd_warp), l)][bus.rs1_addr];
      end
      if (wr_ok_s && (bus.wr_warp == bus.rd_warp) && (bus.wr_addr == bus.rs2_addr)
          && bus.wr_mask[l]) begin
        rs2_next_s[l*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data[l*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        rs2_next_s[l*DATA_WIDTH +: DATA_WIDTH] = mem_r[thread_of(int'(bus.rd_warp), l)][bus.rs2_addr];
      end
    end
  end

  // Registered read data, read-valid and write-error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_data_r <= '0;
      rs2_data_r <= '0;
      rd_valid_r <= 1'b0;
      wr_err_r   <= 1'b0;
    end else begin
      wr_err_r   <= bus.wr_en && !wr_ok_s;
      rd_valid_r <= ready_s && bus.rd_en;
      if (ready_s && bus.rd_en) begin
        rs1_data_r <= rs1_next_s;
        rs2_data_r <= rs2_next_s;
      end
    end
  end

  assign bus.ready    = ready_s;
  assign bus.rs1_data = rs1_data_r;
  assign bus.rs2_data = rs2_data_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.wr_err   = wr_err_r;
endmodule

// File: tb/tb_warp_register_file.sv
// Directed plus randomized bench for warp_register_file with a per-thread
// array model of the register contents.
module tb_warp_register_file;
  localparam int DW = 16;
  localparam int NW = 4;
  localparam int WS = 8;
  localparam int NR = 16;
  localparam int NT = NW * WS;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [DW-1:0]    ref_mem [NT][NR];
  logic [WS*DW-1:0] last_rs1;
  logic [WS*DW-1:0] last_rs2;
  logic [WS*DW-1:0] v1;
  logic [WS*DW-1:0] v2;

  warp_rf_if #(.DATA_WIDTH(DW), .NUM_WARPS(NW), .WARP_SIZE(WS), .NUM_REGS(NR)) bus ();

  warp_register_file #(.DATA_WIDTH(DW), .NUM_WARPS(NW), .WARP_SIZE(WS), .NUM_REGS(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WS*DW-1:0] obs, input logic [WS*DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // New block: thread id, block index and block dim in the top three registers, zero elsewhere
  function automatic void model_init(input logic [DW-1:0] idx, input logic [DW-1:0] dim);
    for (int t = 0; t < NT; t++) begin
      for (int r = 0; r < NR; r++) ref_mem[t][r] = '0;
      ref_mem[t][NR-3] = DW'(t);
      ref_mem[t][NR-2] = idx;
      ref_mem[t][NR-1] = dim;
    end
  endfunction

  function automatic void model_write(input int w, input int r, input logic [WS-1:0] m,
                                      input logic [WS*DW-1:0] d);
    for (int l = 0; l < WS; l++)
      if (m[l]) ref_mem[w*WS+l][r] = d[l*DW +: DW];
  endfunction

  function automatic logic [WS*DW-1:0] model_vec(input int w, input int r);
    logic [WS*DW-1:0] v;
    for (int l = 0; l < WS; l++) v[l*DW +: DW] = ref_mem[w*WS+l][r];
    return v;
  endfunction

  task automatic idle();
    bus.init_start = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic do_write(input int w, input int r, input logic [WS-1:0] m, input logic [WS*DW-1:0] d);
    bus.wr_en = 1'b1;
    bus.wr_warp = 2'(w);
    bus.wr_addr = 4'(r);
    bus.wr_mask = m;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  // Read both sources, compare with the model, then confirm valid drops and data holds
  task automatic do_read(input string tag, input int w, input int a1, input int a2);
    bus.rd_en = 1'b1;
    bus.rd_warp = 2'(w);
    bus.rs1_addr = 4'(a1);
    bus.rs2_addr = 4'(a2);
    last_rs1 = model_vec(w, a1);
    last_rs2 = model_vec(w, a2);
    tick();
    bus.rd_en = 1'b0;
    check({tag, " valid"}, {127'd0, bus.rd_valid}, 128'd1);
    check({tag, " rs1"}, bus.rs1_data, last_rs1);
    check({tag, " rs2"}, bus.rs2_data, last_rs2);
    tick();
    check({tag, " valid drop"}, {127'd0, bus.rd_valid}, 128'd0);
    check({tag, " rs1 hold"}, bus.rs1_data, last_rs1);
  endtask

  task automatic count_init(input string tag, input int edges);
    for (int e = 1; e <= edges; e++) begin
      tick();
      check($sformatf("%s ready edge %0d", tag, e), {127'd0, bus.ready}, (e == edges) ? 128'd1 : 128'd0);
    end
  endtask

  initial begin
    logic             we;
    logic             re;
    logic             exp_err;
    int               ww;
    int               wa;
    int               rw;
    int               a1;
    int               a2;
    logic [WS-1:0]    wm;
    logic [WS*DW-1:0] wd;

    n_checks = 0;
    n_fail = 0;
    clk = 1'b0;
    reset = 1'b1;
    idle();
    bus.block_idx = 16'd2;
    bus.block_dim = 16'd32;
    bus.wr_warp = '0; bus.wr_addr = '0; bus.wr_mask = '0; bus.wr_data = '0;
    bus.rd_warp = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;
    last_rs1 = '0;
    last_rs2 = '0;
    tick(); tick(); tick();
    check("reset ready", {127'd0, bus.ready}, 128'd0);
    check("reset rd_valid", {127'd0, bus.rd_valid}, 128'd0);
    check("reset wr_err", {127'd0, bus.wr_err}, 128'd0);
    check("reset rs1", bus.rs1_data, 128'd0);
    check("reset rs2", bus.rs2_data, 128'd0);

    // Power-up INIT: block_idx changed after the first INIT cycle must be ignored
    reset = 1'b0;
    tick();
    check("boot ready edge 1", {127'd0, bus.ready}, 128'd0);
    bus.block_idx = 16'd9;
    count_init("boot", 3);
    model_init(16'd2, 16'd32);

    // Specials of warp 3 from the formulas directly
    bus.rd_en = 1'b1; bus.rd_warp = 2'd3; bus.rs1_addr = 4'd13; bus.rs2_addr = 4'd14;
    tick();
    for (int l = 0; l < WS; l++) begin
      v1[l*DW +: DW] = 16'(24 + l);
      v2[l*DW +: DW] = 16'd2;
    end
    check("special tid", bus.rs1_data, v1);
    check("special idx", bus.rs2_data, v2);
    bus.rs1_addr = 4'd15; bus.rs2_addr = 4'd15;
    tick();
    bus.rd_en = 1'b0;
    for (int l = 0; l < WS; l++) v1[l*DW +: DW] = 16'd32;
    check("special dim rs1", bus.rs1_data, v1);
    check("special dim rs2", bus.rs2_data, v1);
    last_rs1 = v1;
    last_rs2 = v1;

    // Masked write to warp 1 r5
    for (int l = 0; l < WS; l++) wd[l*DW +: DW] = 16'h100 + 16'(l);
    do_write(1, 5, 8'b1010_0101, wd);
    model_write(1, 5, 8'b1010_0101, wd);
    check("masked write err", {127'd0, bus.wr_err}, 128'd0);
    for (int l = 0; l < WS; l++) v1[l*DW +: DW] = (l == 0 || l == 2 || l == 5 || l == 7) ? 16'h100 + 16'(l) : 16'd0;
    check("masked write model", model_vec(1, 5), v1);
    do_read("w1r5", 1, 5, 5);
    do_read("w0r5", 0, 5, 13);

    // Same-cycle write and read of warp 2 r3
    for (int l = 0; l < WS; l++) wd[l*DW +: DW] = 16'h1230 + 16'(l);
    do_write(2, 3, 8'hFF, wd);
    model_write(2, 3, 8'hFF, wd);
    for (int l = 0; l < WS; l++) wd[l*DW +: DW] = 16'hAAAA;
    bus.wr_en = 1'b1; bus.wr_warp = 2'd2; bus.wr_addr = 4'd3; bus.wr_mask = 8'h0F; bus.wr_data = wd;
    bus.rd_en = 1'b1; bus.rd_warp = 2'd2; bus.rs1_addr = 4'd3; bus.rs2_addr = 4'd3;
    tick();
    idle();
    for (int l = 0; l < WS; l++) v1[l*DW +: DW] = (l < 4) ? 16'hAAAA : 16'h1230 + 16'(l);
    model_write(2, 3, 8'h0F, wd);
    check("bypass valid", {127'd0, bus.rd_valid}, 128'd1);
    check("bypass rs1", bus.rs1_data, v1);
    check("bypass rs2", bus.rs2_data, v1);
    last_rs1 = v1;
    last_rs2 = v1;

    // Write to a special register is rejected
    do_write(1, 14, 8'hFF, {8{16'hDEAD}});
    check("special write err", {127'd0, bus.wr_err}, 128'd1);
    tick();
    check("special write err one cycle", {127'd0, bus.wr_err}, 128'd0);
    do_read("w1r14", 1, 14, 14);

    // Randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      ww = $urandom_range(0, NW-1);
      wa = $urandom_range(0, NR-1);
      wm = 8'($urandom);
      wd = {$urandom, $urandom, $urandom, $urandom};
      re = 1'($urandom_range(0, 3) != 0);
      rw = ($urandom_range(0, 1) == 1) ? ww : $urandom_range(0, NW-1);
      a1 = ($urandom_range(0, 1) == 1) ? wa : $urandom_range(0, NR-1);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : $urandom_range(0, NR-1);
      bus.wr_en = we; bus.wr_warp = 2'(ww); bus.wr_addr = 4'(wa); bus.wr_mask = wm; bus.wr_data = wd;
      bus.rd_en = re; bus.rd_warp = 2'(rw); bus.rs1_addr = 4'(a1); bus.rs2_addr = 4'(a2);
      exp_err = we && (wa >= NR-3);
      if (we && wa < NR-3) model_write(ww, wa, wm, wd);
      if (re) begin
        last_rs1 = model_vec(rw, a1);
        last_rs2 = model_vec(rw, a2);
      end
      tick();
      check($sformatf("rand%0d valid", i), {127'd0, bus.rd_valid}, {127'd0, re});
      check($sformatf("rand%0d err", i), {127'd0, bus.wr_err}, {127'd0, exp_err});
      check($sformatf("rand%0d rs1", i), bus.rs1_data, last_rs1);
      check($sformatf("rand%0d rs2", i), bus.rs2_data, last_rs2);
    end
    idle();
    tick();

    // init_start together with a write to r0, then a write during INIT
    bus.init_start = 1'b1; bus.block_idx = 16'd3;
    bus.wr_en = 1'b1; bus.wr_warp = 2'd0; bus.wr_addr = 4'd0; bus.wr_mask = 8'hFF; bus.wr_data = {8{16'h5555}};
    tick();
    check("reinit write err", {127'd0, bus.wr_err}, 128'd0);
    check("reinit ready edge 0", {127'd0, bus.ready}, 128'd0);
    bus.init_start = 1'b0;
    bus.wr_addr = 4'd1;
    tick();
    check("init write err", {127'd0, bus.wr_err}, 128'd1);
    bus.wr_en = 1'b0;
    bus.block_idx = 16'd7;
    check("reinit ready edge 1", {127'd0, bus.ready}, 128'd0);
    count_init("reinit", 3);
    model_init(16'd3, 16'd32);
    do_read("after init r0 r14", 0, 0, 14);
    do_read("after init w2", 2, 1, 13);

    // Restart the sweep part way through INIT
    bus.init_start = 1'b1; bus.block_idx = 16'd5;
    tick();
    bus.init_start = 1'b0;
    tick();
    tick();
    bus.init_start = 1'b1; bus.block_idx = 16'd6;
    tick();
    check("restart ready edge 0", {127'd0, bus.ready}, 128'd0);
    bus.init_start = 1'b0;
    tick();
    check("restart ready edge 1", {127'd0, bus.ready}, 128'd0);
    bus.block_idx = 16'd8;
    count_init("restart", 3);
    model_init(16'd6, 16'd32);
    do_read("after restart", 1, 14, 13);

    // Reset in the middle of a read
    do_write(3, 7, 8'hFF, {8{16'h7777}});
    bus.rd_en = 1'b1; bus.rd_warp = 2'd3; bus.rs1_addr = 4'd7; bus.rs2_addr = 4'd14;
    tick();
    check("pre-reset valid", {127'd0, bus.rd_valid}, 128'd1);
    check("pre-reset rs1", bus.rs1_data, {8{16'h7777}});
    #2;
    reset = 1'b1;
    #1;
    check("mid reset valid", {127'd0, bus.rd_valid}, 128'd0);
    check("mid reset rs1", bus.rs1_data, 128'd0);
    check("mid reset rs2", bus.rs2_data, 128'd0);
    check("mid reset ready", {127'd0, bus.ready}, 128'd0);
    idle();
    last_rs1 = '0;
    last_rs2 = '0;
    tick();
    bus.block_idx = 16'd4; bus.block_dim = 16'd8;
    reset = 1'b0;
    count_init("post reset", 4);
    model_init(16'd4, 16'd8);
    for (int w = 0; w < NW; w++) begin
      for (int r = 0; r < NR-3; r += 2) begin
        do_read($sformatf("clear w%0d r%0d", w, r), w, r, (r + 1 < NR-3) ? r + 1 : NR-2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/warp_register_file.md
WARP_REGISTER_FILE -- requirements
Module: warp_register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: register width in bits.
REQ-002 SHALL have parameter NUM_WARPS, default 4: warps per block.
REQ-003 SHALL have parameter WARP_SIZE, default 8: threads (lanes) per warp.
REQ-004 SHALL have parameter NUM_REGS, default 16: registers per thread; top three are read-only specials.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 init_start  in  1  pulse: reload specials and clear general registers for a new block.
REQ-008 block_idx  in  DATA_WIDTH  block index, sampled on init entry.
REQ-009 block_dim  in  DATA_WIDTH  threads per block, sampled on init entry.
REQ-010 ready  out  1  high when the file accepts reads and writes.
REQ-011 wr_en  in  1  write request.
REQ-012 wr_warp  in  $clog2(NUM_WARPS)  target warp.
REQ-013 wr_addr  in  $clog2(NUM_REGS)  target register.
REQ-014 wr_mask  in  WARP_SIZE  per-lane write enable.
REQ-015 wr_data  in  WARP_SIZE*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-016 wr_err  out  1  one-cycle pulse for a rejected write.
REQ-017 rd_en  in  1  read request.
REQ-018 rd_warp  in  $clog2(NUM_WARPS)  warp to read.
REQ-019 rs1_addr, rs2_addr  in  $clog2(NUM_REGS) each  source registers.
REQ-020 rs1_data, rs2_data  out  WARP_SIZE*DATA_WIDTH each  registered read data, same lane packing.
REQ-021 rd_valid  out  1  rs1_data/rs2_data valid this cycle.

Function
REQ-022 Specials: thread t = w*WARP_SIZE+l SHALL hold reg NUM_REGS-3 = t, NUM_REGS-2 = latched block_idx, NUM_REGS-1 = latched block_dim.
REQ-023 FSM states SHALL be INIT and READY; ready = (state==READY).
REQ-024 INIT SHALL sweep one warp per cycle (counter 0..NUM_WARPS-1): general registers cleared to 0, specials written per REQ-022; after the NUM_WARPS-th cycle -> READY.
REQ-025 block_idx/block_dim SHALL be latched on the cycle INIT is entered; changes during INIT ignored.
REQ-026 init_start in READY SHALL enter INIT next cycle; init_start during INIT SHALL restart the sweep at warp 0 and relatch block_idx/block_dim.
REQ-027 In READY, wr_en SHALL write wr_data lane l into reg[wr_warp*WARP_SIZE+l][wr_addr] for every l with wr_mask[l]=1; other lanes unchanged.
REQ-028 wr_en with wr_addr >= NUM_REGS-3 SHALL write nothing and pulse wr_err the next cycle.
REQ-029 wr_en while not ready SHALL write nothing and pulse wr_err the next cycle.
REQ-030 In READY, rd_en SHALL register both sources of warp rd_warp; data and rd_valid=1 appear on the next cycle (latency 1).
REQ-031 rd_en=0 or not ready SHALL drive rd_valid=0 next cycle; rs1_data/rs2_data hold their previous values.
REQ-032 Same-cycle write and read of the same warp and register SHALL return new data on masked lanes and old data on unmasked lanes (write-first bypass), independently per port.
REQ-033 rs1_addr == rs2_addr SHALL return identical data on both ports.
REQ-034 init_start and wr_en in the same READY cycle: the write SHALL be performed, then INIT overwrites.

Reset
REQ-035 While reset is asserted: all registers 0, latched block values 0, state INIT at warp 0, ready=0, rd_valid=0, wr_err=0, rs1_data=rs2_data=0.
REQ-036 After reset deasserts, INIT SHALL run automatically; ready rises exactly NUM_WARPS rising edges later.
REQ-037 Reset asserted mid-INIT or mid-access SHALL abort it immediately and restart per REQ-035/036.

Verification
REQ-038 Defaults, block_idx=2, block_dim=32, release reset -> ready high after 4 clocks; read warp 3 regs 13/14/15 -> lane l returns 24+l, 2, 32.
REQ-039 Write warp 1 r5, mask 8'b1010_0101, lane l = 0x100+l -> read r5 gives 0x100+l on lanes 0,2,5,7, 0 elsewhere; warp 0 r5 unchanged (0).
REQ-040 Same-cycle write warp 2 r3 = 0xAAAA, mask 0x0F, with read rs1=rs2=r3 warp 2 -> next cycle lanes 0-3 = 0xAAAA, lanes 4-7 = old value, rd_valid=1.
REQ-041 Write r14 in READY -> wr_err pulses one cycle, r14 unchanged; write during INIT -> wr_err, no change.
REQ-042 init_start with block_idx=3 after writing r0 -> ready low 4 cycles; afterwards r0 = 0, r14 = 3; reassert init_start during INIT -> sweep restarts, ready after 4 more cycles.
REQ-043 Assert reset mid-read -> rd_valid and data 0 immediately; after release, INIT completes and all general registers read 0.
